capture_sequencer: RTL
======================

Name: capture_sequencer

Overview:
- Run controller for the sampling datapath (strober -> serializer/compressor -> output stream).
- Host issues arm/abort. Block clears the sample timer and index, enables sampling, and fills a pre-trigger window.
- It then waits for a pattern/edge trigger on the synchronized inputs, counts post-trigger samples and stops.
- Reports state, trigger sample index and completion to the register block.

Parameters:
- W, 16, number of input channels.
- CW, 32, width of the pre/post sample counters and the trigger index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- arm  in  1  pulse: start a capture run (ignored unless IDLE or DONE)
- abort  in  1  pulse: stop the run immediately
- s  in  W  synchronized channel values, same cycle as sample_strobe
- sample_strobe  in  1  one sample taken this cycle
- trig_mask  in  W  channels taking part in the level match
- trig_value  in  W  required levels on masked channels
- trig_rise  in  W  channels whose rising edge is required (any of them)
- trig_fall  in  W  channels whose falling edge is required (any of them)
- pre_count  in  CW  samples to take before trigger is honoured
- post_count  in  CW  samples to take after trigger, trigger sample included
- sampler_enable  out  1  enable to strober timer and stream gating
- clear_pulse  out  1  one-cycle clear for timer, sample index, compressor
- state  out  3  current state encoding
- busy  out  1  state is neither IDLE nor DONE
- triggered  out  1  trigger seen in the current run
- trig_index  out  CW  sample count at the trigger sample
- done  out  1  one-cycle pulse when the run completes normally

Behaviour:
- Reset values: state IDLE, all outputs 0, internal counters 0, last_s 0.
- Only rst is synchronous; every register updates on the rising edge of clk.
- State encoding: IDLE=0, CLEAR=1, PRE=2, ARMED=3, POST=4, DONE=5.
- IDLE/DONE + arm -> CLEAR.
  - In CLEAR: clear_pulse=1 for exactly 1 cycle; sample_cnt, triggered and trig_index are zeroed.
  - Next state is PRE.
- PRE:
  - sampler_enable=1; each sample_strobe increments sample_cnt.
  - Go to ARMED on the cycle sample_cnt reaches pre_count.
  - pre_count=0: PRE lasts exactly 1 cycle, then ARMED.
- ARMED:
  - sampler_enable=1. last_s is updated on every sample_strobe.
  - Trigger fires on a strobe cycle when all three hold:
    - ((s ^ trig_value) & trig_mask)==0;
    - edge term true: (trig_rise|trig_fall)==0, or any bit of (~last_s & s & trig_rise) | (last_s & ~s & trig_fall);
    - the strobe is not the first strobe in ARMED (last_s must be valid).
  - On fire: triggered<=1, trig_index<=sample_cnt, post_cnt<=1, state<=POST (or DONE if post_count<=1).
- POST:
  - sampler_enable=1; each strobe increments post_cnt.
  - When a strobe makes post_cnt==post_count: sampler_enable<=0 the following cycle, state<=DONE, done=1 for 1 cycle.
- Counter saturation: sample_cnt and post_cnt saturate at all-ones; no wrap.
- abort: any state other than IDLE -> IDLE next cycle.
  - sampler_enable drops next cycle; triggered and trig_index are kept; no done pulse.
- Priority: rst > abort > arm > trigger/count.
  - arm while busy is ignored.
  - arm and abort in the same cycle: abort wins.
- Strobe and state-exit coincide: the strobe is counted in the state being left; it is not re-evaluated as a trigger.
- Sampler_enable-to-stream latency is 1 cycle; strobes arriving while disabled are ignored.

Optional Feature:
- CAPTURE_SEQ_TIMEOUT_EN: adds input timeout (CW) and output timed_out (1, reset 0).
  - In ARMED a cycle counter runs. When it reaches a nonzero timeout, the block forces a trigger at the current sample_cnt with timed_out=1.
  - timed_out is cleared in CLEAR.
  - timeout=0 disables the counter.
- Without the macro: no ports, no counter; ARMED waits indefinitely.

Decomposition:
- Package capture_seq_pkg holds:
  - state encoding localparams;
  - default W/CW;
  - a function computing the edge mask from last_s, s, rise and fall masks.
- One sub-module: capture_trigger_match (combinational+1 reg: holds last_s, outputs the fire condition). The FSM and counters stay in the top.

Test Plan:
- Immediate trigger: pre=0, post=4, mask=0, no edges, strobe every 2nd cycle, arm.
  - clear_pulse on 1 cycle; trigger on 2nd ARMED strobe; trig_index=1.
  - done after 4 post strobes; sampler_enable low the cycle after.
- Pattern: pre=3, mask=0x000F, value=0x0005, s ramps 0..15 per strobe.
  - No trigger before 3 strobes; fire at s=0x0005 with trig_index=5; state=POST.
- Edge: trig_rise=0x0100, s toggles bit 8 every 3 strobes, post=1.
  - Fires only on a 0->1 transition of bit 8; goes straight to DONE; done pulse width=1.
- Abort in POST: post=100, abort at post_cnt=10.
  - state=IDLE next cycle; no done pulse; triggered=1 and trig_index retained.
  - arm+abort in the same cycle while in IDLE leaves the block in IDLE.
- Saturation: pre=0xFFFFFFFF with a forced sample_cnt near max (or small CW=4 build, pre=15).
  - Counter stops at 15, never wraps to 0; ARMED reached exactly at 15.
- CAPTURE_SEQ_TIMEOUT_EN: timeout=20, no trigger condition.
  - Forced trigger 20 cycles after entering ARMED; timed_out=1.
  - Re-arm clears timed_out.

Source files
------------

// File: rtl/capture_seq_pkg.sv
// Shared types, default sizes and the edge-detect helper for the capture sequencer.
package capture_seq_pkg;

    localparam int unsigned W_DEF     = 16;
    localparam int unsigned CW_DEF    = 32;
    localparam int unsigned EDGE_MAXW = 256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PRE   = 3'd2,
        ST_ARMED = 3'd3,
        ST_POST  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Operands are zero-extended by the caller; bits above the channel count never hit.
    function automatic logic [EDGE_MAXW-1:0] edge_mask(
        input logic [EDGE_MAXW-1:0] last_s,
        input logic [EDGE_MAXW-1:0] s,
        input logic [EDGE_MAXW-1:0] rise,
        input logic [EDGE_MAXW-1:0] fall
    );
        return (~last_s & s & rise) | (last_s & ~s & fall);
    endfunction

endpackage

// File: rtl/capture_trigger_match.sv
// Level/edge trigger qualifier: remembers the previous ARMED sample and flags a trigger strobe.
module capture_trigger_match
    import capture_seq_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         track,
    input  logic         sample_strobe,
    input  logic [W-1:0] s,
    input  logic [W-1:0] trig_mask,
    input  logic [W-1:0] trig_value,
    input  logic [W-1:0] trig_rise,
    input  logic [W-1:0] trig_fall,
    output logic         fire
);

    logic [W-1:0] last_s;
    logic         valid;
    logic         level_ok;
    logic         edge_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_s <= '0;
            valid  <= 1'b0;
        end else if (!track) begin
            valid <= 1'b0;
        end else if (sample_strobe) begin
            last_s <= s;
            valid  <= 1'b1;
        end
    end

    // valid stays low until the first strobe of the ARMED stay has been captured.
    always_comb begin
        level_ok = ((s ^ trig_value) & trig_mask) == '0;
        edge_ok  = ((trig_rise | trig_fall) == '0) ||
                   (|edge_mask(EDGE_MAXW'(last_s), EDGE_MAXW'(s),
                               EDGE_MAXW'(trig_rise), EDGE_MAXW'(trig_fall)));
        fire     = track && sample_strobe && valid && level_ok && edge_ok;
    end

endmodule

// File: rtl/capture_sequencer.sv
// Capture run controller: clear, pre-trigger fill, trigger wait, post-trigger count.
// Optional ARMED timeout via `define CAPTURE_SEQ_TIMEOUT_EN.
module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic [W-1:0]  s,
    input  logic          sample_strobe,
    input  logic [W-1:0]  trig_mask,
    input  logic [W-1:0]  trig_value,
    input  logic [W-1:0]  trig_rise,
    input  logic [W-1:0]  trig_fall,
    input  logic [CW-1:0] pre_count,
    input  logic [CW-1:0] post_count,
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    input  logic [CW-1:0] timeout,
    output logic          timed_out,
`endif
    output logic          sampler_enable,
    output logic          clear_pulse,
    output logic [2:0]    state,
    output logic          busy,
    output logic          triggered,
    output logic [CW-1:0] trig_index,
    output logic          done
);

    state_t        st;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] post_cnt;
    logic [CW-1:0] sample_inc;
    logic [CW-1:0] sample_seen;
    logic [CW-1:0] post_inc;
    logic          fire;
    logic          force_trig;
    logic          trig_now;
    logic          arming;
    logic          fire_take;

    capture_trigger_match #(.W(W)) u_match (
        .clk           (clk),
        .rst           (rst),
        .track         (st == ST_ARMED),
        .sample_strobe (sample_strobe),
        .s             (s),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .trig_rise     (trig_rise),
        .trig_fall     (trig_fall),
        .fire          (fire)
    );

    always_comb begin
        sample_inc  = (sample_cnt == '1) ? sample_cnt : sample_cnt + CW'(1);
        post_inc    = (post_cnt == '1) ? post_cnt : post_cnt + CW'(1);
        sample_seen = sample_strobe ? sample_inc : sample_cnt;
        trig_now    = fire || force_trig;
        arming      = ((st == ST_IDLE) || (st == ST_DONE)) && arm && !abort;
        fire_take   = (st == ST_ARMED) && trig_now && !abort;
    end

    assign state = st;
    assign busy  = (st != ST_IDLE) && (st != ST_DONE);

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    logic [CW-1:0] tmo_cnt;

    assign force_trig = (st == ST_ARMED) && (timeout != '0) && (tmo_cnt + CW'(1) == timeout);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            if (st != ST_ARMED) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (arming) begin
                timed_out <= 1'b0;
            end else if (fire_take) begin
                timed_out <= !fire;
            end
        end
    end
`else
    assign force_trig = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= ST_IDLE;
            sampler_enable <= 1'b0;
            clear_pulse    <= 1'b0;
            triggered      <= 1'b0;
            trig_index     <= '0;
            done           <= 1'b0;
            sample_cnt     <= '0;
            post_cnt       <= '0;
        end else begin
            clear_pulse <= 1'b0;
            done        <= 1'b0;
            if (abort && (st != ST_IDLE)) begin
                st             <= ST_IDLE;
                sampler_enable <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE, ST_DONE: begin
                        if (arming) begin
                            st          <= ST_CLEAR;
                            clear_pulse <= 1'b1;
                            sample_cnt  <= '0;
                            post_cnt    <= '0;
                            triggered   <= 1'b0;
                            trig_index  <= '0;
                        end
                    end
                    ST_CLEAR: begin
                        st             <= ST_PRE;
                        sampler_enable <= 1'b1;
                    end
                    ST_PRE: begin
                        if (sample_strobe) sample_cnt <= sample_inc;
                        if (sample_seen >= pre_count) st <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (sample_strobe) sample_cnt <= sample_inc;
                        if (fire_take) begin
                            triggered  <= 1'b1;
                            trig_index <= sample_cnt;
                            post_cnt   <= CW'(1);
                            if (post_count <= CW'(1)) begin
                                st             <= ST_DONE;
                                done           <= 1'b1;
                                sampler_enable <= 1'b0;
                            end else begin
                                st <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample_strobe) begin
                            sample_cnt <= sample_inc;
                            post_cnt   <= post_inc;
                            if (post_inc >= post_count) begin
                                st             <= ST_DONE;
                                done           <= 1'b1;
                                sampler_enable <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        st             <= ST_IDLE;
                        sampler_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
